// File: rtl/rgb2gray_stream_pkg.sv
// Shared image-pipeline constants: pixel widths, BT.601-style luma weights
// and a helper that sizes frame position counters.
package img_pkg;

    localparam int PIX_W  = 8;
    localparam int RGB_W  = 24;
    localparam int PROD_W = 16;

    localparam int Y_CR    = 77;
    localparam int Y_CG    = 150;
    localparam int Y_CB    = 29;
    localparam int Y_RND   = 128;
    localparam int Y_SHIFT = 8;

    // A 1-wide dimension still needs a 1-bit counter.
    function automatic int pos_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb2gray_stream_if.sv
// Pixel stream bundle: RGB in from the capture side, gray + end-of-frame out
// toward the equalizer.
interface rgb2gray_stream_if;
    import img_pkg::*;

    logic             i_valid;
    logic [RGB_W-1:0] i_rgb;
    logic             i_sof;
    logic             o_ready;
    logic             o_valid;
    logic [PIX_W-1:0] o_gray;
    logic             o_end;
    logic             i_ready;

    modport slave (
        input  i_valid, i_rgb, i_sof, i_ready,
        output o_ready, o_valid, o_gray, o_end
    );

    modport master (
        output i_valid, i_rgb, i_sof, i_ready,
        input  o_ready, o_valid, o_gray, o_end
    );

endinterface

// File: rtl/rgb2gray_stream_frame_pos_counter.sv
// Raster position tracker. i_force0 treats the current beat as pixel (0,0),
// both for o_last and for where the count continues after i_step.
import img_pkg::*;

module frame_pos_counter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_step,
    input  logic                     i_force0,
    output logic [pos_w(WIDTH)-1:0]  o_x,
    output logic [pos_w(HEIGHT)-1:0] o_y,
    output logic                     o_last
);

    localparam int X_W = pos_w(WIDTH);
    localparam int Y_W = pos_w(HEIGHT);
    localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] x_q, x_d, base_x;
    logic [Y_W-1:0] y_q, y_d, base_y;

    always_comb begin
        base_x = i_force0 ? '0 : x_q;
        base_y = i_force0 ? '0 : y_q;
        x_d    = x_q;
        y_d    = y_q;
        if (i_step) begin
            if (base_x == X_MAX) begin
                x_d = '0;
                y_d = (base_y == Y_MAX) ? '0 : base_y + Y_W'(1);
            end else begin
                x_d = base_x + X_W'(1);
                y_d = base_y;
            end
        end
    end

    assign o_last = (base_x == X_MAX) && (base_y == Y_MAX);
    assign o_x    = x_q;
    assign o_y    = y_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// RGB -> 8-bit luma front end for hist_eq_core: two-stage pipeline with a
// single global advance, internal frame tracking and sof-based resync.
import img_pkg::*;

module rgb2gray_stream #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rgb2gray_stream_if.slave   px,
    output logic               o_frame_done,
    output logic               o_sync_err
);

    localparam int X_W = pos_w(WIDTH);
    localparam int Y_W = pos_w(HEIGHT);

    function automatic logic [PIX_W-1:0] luma_round(input logic [PROD_W-1:0] sum);
        return PIX_W'(sum >> Y_SHIFT);
    endfunction

    logic              adv, up_xfer, dn_xfer, end_beat, pos_last, misaligned;
    logic [X_W-1:0]    pos_x;
    logic [Y_W-1:0]    pos_y;
    logic [PROD_W-1:0] sum_p1;

    logic              vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d;
    logic [PROD_W-1:0] r_p1_q, r_p1_d, g_p1_q, g_p1_d, b_p1_q, b_p1_d;
    logic              vld_p2_q, vld_p2_d, sof_p2_q, sof_p2_d;
    logic [PIX_W-1:0]  gray_p2_q, gray_p2_d;
    logic              frame_done_q, frame_done_d, sync_err_q, sync_err_d;

    always_comb begin
        adv        = !vld_p2_q || px.i_ready;
        up_xfer    = px.i_valid && adv && !i_rst;
        dn_xfer    = vld_p2_q && px.i_ready;
        end_beat   = vld_p2_q && pos_last;
        misaligned = sof_p2_q && ((pos_x != '0) || (pos_y != '0));
        sum_p1     = r_p1_q + g_p1_q + b_p1_q + PROD_W'(Y_RND);

        vld_p1_d  = vld_p1_q;
        sof_p1_d  = sof_p1_q;
        r_p1_d    = r_p1_q;
        g_p1_d    = g_p1_q;
        b_p1_d    = b_p1_q;
        vld_p2_d  = vld_p2_q;
        sof_p2_d  = sof_p2_q;
        gray_p2_d = gray_p2_q;

        if (adv) begin
            // Stage 1: weighted channel products
            vld_p1_d = up_xfer;
            sof_p1_d = up_xfer && px.i_sof;
            r_p1_d   = PROD_W'(px.i_rgb[23:16]) * PROD_W'(Y_CR);
            g_p1_d   = PROD_W'(px.i_rgb[15:8])  * PROD_W'(Y_CG);
            b_p1_d   = PROD_W'(px.i_rgb[7:0])   * PROD_W'(Y_CB);
            // Stage 2: rounded luma, the output register
            vld_p2_d = vld_p1_q;
            sof_p2_d = sof_p1_q;
            if (vld_p1_q) begin
                gray_p2_d = luma_round(sum_p1);
            end
        end

        frame_done_d = dn_xfer && end_beat;
        sync_err_d   = dn_xfer && misaligned;
    end

    // A sof pixel is always treated as (0,0); only a misplaced one is reported.
    frame_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step   (dn_xfer),
        .i_force0 (sof_p2_q),
        .o_x      (pos_x),
        .o_y      (pos_y),
        .o_last   (pos_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1_q     <= 1'b0;
            sof_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            sof_p2_q     <= 1'b0;
            gray_p2_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            sof_p1_q     <= sof_p1_d;
            vld_p2_q     <= vld_p2_d;
            sof_p2_q     <= sof_p2_d;
            gray_p2_q    <= gray_p2_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        r_p1_q <= r_p1_d;
        g_p1_q <= g_p1_d;
        b_p1_q <= b_p1_d;
    end

    assign px.o_ready   = adv && !i_rst;
    assign px.o_valid   = vld_p2_q;
    assign px.o_gray    = gray_p2_q;
    assign px.o_end     = end_beat;
    assign o_frame_done = frame_done_q;
    assign o_sync_err   = sync_err_q;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream on a 4x2 frame.
module tb_rgb2gray_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_done, sync_err;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    rgb2gray_stream_if bus();

    rgb2gray_stream #(.WIDTH(4), .HEIGHT(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .px           (bus),
        .o_frame_done (frame_done),
        .o_sync_err   (sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream observer: records every transfer and pulse, and flags any
    // output change while stalled.
    logic [7:0] q_gray[$];
    bit         q_end[$];
    int         q_cyc[$];
    int         fd_cyc[$];
    int         se_cnt = 0;
    int         stall_viol = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_gray = 8'd0;
    bit         prev_end = 1'b0;
    int         acc_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            q_gray.delete();
            q_end.delete();
            q_cyc.delete();
            fd_cyc.delete();
            se_cnt     <= 0;
            stall_viol <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                q_gray.push_back(bus.o_gray);
                q_end.push_back(bus.o_end);
                q_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (sync_err) se_cnt <= se_cnt + 1;
            if (prev_stall && (!bus.o_valid || bus.o_gray !== prev_gray || bus.o_end !== prev_end))
                stall_viol <= stall_viol + 1;
            prev_stall <= bus.o_valid && !bus.i_ready;
            prev_gray  <= bus.o_gray;
            prev_end   <= bus.o_end;
        end
    end

    function automatic logic [23:0] gpx(input logic [7:0] v);
        return {v, v, v};   // equal channels: luma is exactly v
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sof = 1'b0;
        bus.i_ready = 1'b1;
        acc_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_px(input logic [23:0] rgb, input logic sof);
        int  guard;
        logic acc;
        guard = 0;
        acc = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_rgb = rgb;
        bus.i_sof = sof;
        while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = bus.o_ready;
            if (acc) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: pixel %h not accepted, required acceptance", rgb);
        end
        bus.i_valid = 1'b0;
        bus.i_sof = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int g;
        g = 0;
        while (q_gray.size() < n && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name, input int n, input int first_v, input int end_a, input int end_b);
        n_cmp++;
        if (q_gray.size() !== n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d required %0d", name, q_gray.size(), n);
        end
        for (int i = 0; i < n && i < q_gray.size(); i++) begin
            n_cmp++;
            if (q_gray[i] !== 8'(first_v + i) || q_end[i] !== (i == end_a || i == end_b)) begin
                n_fail++;
                $display("FAIL %s_px%0d: got gray %0d end %0d required gray %0d end %0d",
                         name, i, q_gray[i], q_end[i], first_v + i, (i == end_a || i == end_b));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_rgb = 24'hFFFFFF;
        bus.i_sof = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp += 6;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", bus.o_valid); end
        if (bus.o_gray !== 8'd0) begin n_fail++; $display("FAIL rst_gray: got %0d required 0", bus.o_gray); end
        if (bus.o_end !== 1'b0) begin n_fail++; $display("FAIL rst_end: got %b required 0", bus.o_end); end
        if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", bus.o_ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL rst_sync_err: got %b required 0", sync_err); end
        do_reset();
    endtask

    task automatic test_luma();
        logic [23:0] rgb_t[5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
        logic [7:0]  exp_t[5] = '{8'd77, 8'd149, 8'd29, 8'd255, 8'd0};
        do_reset();
        for (int i = 0; i < 5; i++) send_px(rgb_t[i], i == 0);
        wait_out(5);
        for (int i = 0; i < 5 && i < q_gray.size(); i++) begin
            n_cmp += 2;
            if (q_gray[i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL luma_%0d: got %0d required %0d", i, q_gray[i], exp_t[i]);
            end
            if (q_cyc[i] - acc_cyc[i] !== 2) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d required 2", i, q_cyc[i] - acc_cyc[i]);
            end
        end
        n_cmp++;
        if (q_gray.size() !== 5) begin n_fail++; $display("FAIL luma_count: got %0d required 5", q_gray.size()); end
    endtask

    task automatic test_frame_stalls();
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++) send_px(gpx(8'(10 + i)), i == 0);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    bus.i_ready = (k < 4) ? 1'b0 : ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.i_ready = 1'b1;
            end
        join
        wait_out(8);
        check_stream("stall_frame", 8, 10, 7, 7);
        n_cmp += 3;
        if (fd_cyc.size() !== 1 || (q_cyc.size() == 8 && fd_cyc[0] !== q_cyc[7] + 1)) begin
            n_fail++;
            $display("FAIL stall_frame_done: got %0d pulses required 1 one cycle after end", fd_cyc.size());
        end
        if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes required 0", stall_viol); end
        if (se_cnt !== 0) begin n_fail++; $display("FAIL stall_sync_err: got %0d required 0", se_cnt); end
    endtask

    task automatic test_long_stall();
        int rdy_hi;
        do_reset();
        bus.i_ready = 1'b0;
        send_px(gpx(8'd1), 1'b1);
        send_px(gpx(8'd2), 1'b0);
        bus.i_valid = 1'b1;
        bus.i_rgb = gpx(8'd3);
        rdy_hi = 0;
        repeat (512) begin
            @(negedge clk);
            if (bus.o_ready) rdy_hi++;
        end
        n_cmp += 2;
        if (rdy_hi !== 0) begin n_fail++; $display("FAIL long_ready: got %0d ready cycles required 0", rdy_hi); end
        if (bus.o_valid !== 1'b1 || bus.o_gray !== 8'd1) begin
            n_fail++;
            $display("FAIL long_head: got valid %b gray %0d required valid 1 gray 1", bus.o_valid, bus.o_gray);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        for (int i = 3; i <= 5; i++) send_px(gpx(8'(i)), 1'b0);
        wait_out(5);
        check_stream("long_stall", 5, 1, -1, -1);
        for (int i = 1; i < 5 && i < q_cyc.size(); i++) begin
            n_cmp++;
            if (q_cyc[i] - q_cyc[i-1] !== 1) begin
                n_fail++;
                $display("FAIL long_rate_%0d: got gap %0d required 1", i, q_cyc[i] - q_cyc[i-1]);
            end
        end
        n_cmp++;
        if (stall_viol !== 0) begin n_fail++; $display("FAIL long_hold: got %0d changes required 0", stall_viol); end
    endtask

    task automatic test_early_sof();
        do_reset();
        for (int i = 0; i < 11; i++) send_px(gpx(8'(30 + i)), i == 0 || i == 3);
        wait_out(11);
        check_stream("early_sof", 11, 30, 10, 10);
        n_cmp += 2;
        if (se_cnt !== 1) begin n_fail++; $display("FAIL early_sync_err: got %0d pulses required 1", se_cnt); end
        if (fd_cyc.size() !== 1) begin n_fail++; $display("FAIL early_frame_done: got %0d required 1", fd_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) send_px(gpx(8'(50 + i)), i == 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp += 4;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b required 0", bus.o_valid); end
        if (bus.o_gray !== 8'd0) begin n_fail++; $display("FAIL mid_gray: got %0d required 0", bus.o_gray); end
        if (bus.o_end !== 1'b0) begin n_fail++; $display("FAIL mid_end: got %b required 0", bus.o_end); end
        if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b required 0", bus.o_ready); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_px(gpx(8'(70 + i)), 1'b0);
        wait_out(8);
        check_stream("mid_restart", 8, 70, 7, 7);
        n_cmp++;
        if (se_cnt !== 0) begin n_fail++; $display("FAIL mid_sync_err: got %0d required 0", se_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) send_px(gpx(8'(100 + i)), i == 0 || i == 8);
        wait_out(16);
        check_stream("b2b", 16, 100, 7, 15);
        n_cmp += 2;
        if (fd_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d required 2", fd_cyc.size()); end
        if (se_cnt !== 0) begin n_fail++; $display("FAIL b2b_sync_err: got %0d required 0", se_cnt); end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_rgb = 24'd0;
        bus.i_sof = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        test_reset();
        test_luma();
        test_frame_stalls();
        test_long_stall();
        test_early_sof();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb2gray_stream.md
# rgb2gray_stream

Front-end pixel transmitter for `hist_eq_core`. It accepts a 24-bit RGB pixel stream from the capture/readout side and converts each pixel to 8-bit luma. It emits a valid/ready stream with a last-pixel frame marker on exactly the `i_valid` / `i_gray` / `i_end` / `o_in_ready` interface that the equalizer consumes. Frame position is tracked internally, so `i_end` is generated here and never taken from upstream.

## Interface
- `WIDTH`, 320, pixels per line
- `HEIGHT`, 240, lines per frame
- `i_clk`  in  1  single clock for the whole block
- `i_rst`  in  1  reset; **synchronous, active-high**
- `i_valid`  in  1  upstream RGB pixel valid
- `i_rgb`  in  24  R=[23:16], G=[15:8], B=[7:0]
- `i_sof`  in  1  upstream start-of-frame; qualified by `i_valid`
- `o_ready`  out  1  upstream may transfer this cycle
- `o_valid`  out  1  gray pixel valid (to core `i_valid`)
- `o_gray`  out  8  luma (to core `i_gray`)
- `o_end`  out  1  last pixel of frame, same beat as that pixel (to core `i_end`)
- `i_ready`  in  1  downstream ready (from core `o_in_ready`)
- `o_frame_done`  out  1  one-cycle pulse after the `o_end` beat transfers
- `o_sync_err`  out  1  one-cycle pulse on `i_sof` misalignment

## Operation
- **Luma formula:** gray = (77·R + 150·G + 29·B + 128) >> 8.
  - Products are 16-bit; the sum is held in 16 bits.
  - Max sum is 65408, so there is no overflow and the result saturates naturally at 255.
- **Pipeline:** two stages.
  - S1 registers the three products plus the sof flag.
  - S2 registers the summed and shifted gray plus the sof flag.
  - S2 is the output register.
- **Flow control:**
  - `adv = !o_valid || i_ready`.
  - All stages load only when `adv` is high.
  - `o_ready = adv && !i_rst`, combinational.
  - An upstream transfer is `i_valid && o_ready`.
  - A downstream transfer is `o_valid && i_ready`.
  - Bubbles propagate as valid=0.
- **Output stability:** while `o_valid && !i_ready`, `o_gray`, `o_end` and `o_valid` hold stable.
- **Position counters:** `x` (0..WIDTH-1) and `y` (0..HEIGHT-1) advance on each downstream transfer.
  - `x` wraps to 0 and increments `y`.
  - At x=WIDTH-1, y=HEIGHT-1 both return to 0.
- **`o_end` generation:** combinational, `o_end = o_valid && x==WIDTH-1 && y==HEIGHT-1`.
- **`o_frame_done`:** registered, high the cycle after the `o_end` transfer.
- **Frame resync:** if the S2 sof flag is set and (x,y) ≠ (0,0) when that pixel transfers:
  - `o_sync_err` pulses the next cycle.
  - The pixel is emitted as pixel (0,0), with `o_end` computed from (0,0).
  - The counters continue from (1,0).
- **Sof at (0,0):** a sof flag on a pixel already at (0,0) is silent.
- **Sof on pixel 0 of a 1×1 frame:** `o_end` and sof alignment are both valid.
- **Long stalls:** `hist_eq_core` holds `o_in_ready` low for about 512 cycles during LUT build. The block simply stalls, with no loss and no duplication.

## Timing
- **Reset values:** `o_valid` 0, `o_gray` 0, `o_end` 0, `o_frame_done` 0, `o_sync_err` 0, `o_ready` 0, both stage valids 0, x=y=0.
- **Reset mid-frame:** the in-flight pixels are discarded.
  - The first pixel after reset is (0,0) whether or not `i_sof` is set.
- **Latency:** an upstream transfer at cycle N appears on `o_gray` at N+2 when `i_ready` stays high.
- **Throughput:** one pixel per clock at sustained `i_ready`.
- **Ready path:** `o_ready` depends combinationally on `i_ready`. The upstream source must not make `i_valid` depend on `o_ready`.
- **Pulse outputs:** `o_frame_done` and `o_sync_err` are exactly one cycle long and are never asserted during reset.
- **Coincident events:** if both occur on the same transfer (sof misaligned and forced to (0,0) while WIDTH=HEIGHT=1), both pulse in the same cycle.

## Structure
- **Shared package `img_pkg`:**
  - `PIX_W`=8, `RGB_W`=24
  - luma coefficients `Y_CR`=77, `Y_CG`=150, `Y_CB`=29, `Y_RND`=128, `Y_SHIFT`=8
- **Sub-module `frame_pos_counter`:** parameters `WIDTH`/`HEIGHT`; inputs `i_clk`, `i_rst`, `i_step`, `i_force0`; outputs `o_x`, `o_y`, `o_last`. `hist_eq_core`'s output side will also reuse it.
- **Top level:** the luma pipeline, flow control and pulse registers.

## Test plan
- **Luma reference values:** RGB 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF, 0x000000 with `i_ready`=1 → `o_gray` 77, 149, 29, 255, 0. Each appears exactly 2 cycles after acceptance.
- **Full frame with random stalls:** WIDTH=4, HEIGHT=2, 8 pixels streamed, `i_ready` randomly low → exactly 8 downstream transfers in order, `o_end` only on the 8th, `o_frame_done` pulse one cycle later, output held stable during every stall.
- **Long stall:** `i_ready` low for 512 cycles with the pipeline full → `o_ready`=0 throughout, no pixel lost or repeated, and output resumes at one per cycle.
- **Early sof:** `i_sof` on pixel 3 of a 4×2 frame → `o_sync_err` pulses once, and `o_end` lands on the 8th pixel counted from the sof pixel.
- **Reset mid-frame:** `i_rst` high for 1 cycle after 5 pixels → all outputs go to their reset values the next cycle, and `o_end` follows 8 pixels after restart.
- **Back-to-back frames:** two 4×2 frames with no gap → `o_end` on transfers 8 and 16, and `o_frame_done` pulses twice.
